router_dest_reader: RTL and testbench
=====================================

Name: router_dest_reader

Overview:
- Destination-side consumer for one router output port.
- Watches vld_out, drives read_enb, and pulls a full packet from the output FIFO: header, payload, parity.
- Checks parity and streams payload bytes to a local sink, reporting done, error and abort status.
- One instance sits on each of the three router output ports, at the far end of the write path that router_sync decodes.

Parameters:
READ_DELAY, 4, cycles to wait after vld_out rises before the header read; must be < 30 so the router soft-reset timeout is not hit.
TIMEOUT, 64, stall limit in cycles; used only with the optional feature.

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
vld_out  in  1  router output FIFO non-empty
data_out  in  8  FIFO read data; valid the cycle after read_enb=1
soft_reset  in  1  router soft reset for this port
rx_ready  in  1  sink can accept payload
read_enb  out  1  FIFO read strobe
rx_data  out  8  payload byte
rx_valid  out  1  rx_data valid, single-cycle pulse per byte
pkt_addr  out  2  header[1:0] of the current or last packet
pkt_len  out  6  header[7:2] of the current or last packet
pkt_done  out  1  one-cycle pulse at packet end
pkt_err  out  1  parity mismatch; valid with pkt_done
pkt_abort  out  1  one-cycle pulse when a packet is abandoned
pkt_count  out  8  completed packets, wraps 255->0
busy  out  1  state != IDLE

Behaviour:
- Reset: every output = 0; state = IDLE; all counters and parity accumulator = 0.
- Packet format: header {len[5:0], addr[1:0]}, then len payload bytes, then one parity byte.
  - Expected parity = XOR of header and all payload bytes.
- Read latency: data_out is captured the cycle after read_enb=1. read_enb is only ever asserted when vld_out=1.
- IDLE:
  - read_enb=0.
  - vld_out=1 -> DELAY with cnt=0; if READ_DELAY=0, go directly to HDR_RD.
- DELAY:
  - cnt increments each cycle.
  - cnt==READ_DELAY-1 -> HDR_RD.
  - vld_out dropping during DELAY -> IDLE, no abort.
- HDR_RD: read_enb=1 when vld_out=1, then -> HDR_CAP. If vld_out=0, stay.
- HDR_CAP:
  - read_enb=0.
  - Capture header: pkt_len, pkt_addr, parity accumulator = header, remaining = len+1.
  - -> BODY.
- BODY:
  - read_enb = vld_out & rx_ready & (issued < len+1).
  - Each captured byte with index < len: rx_data=byte, rx_valid=1, accumulator ^= byte.
  - Byte index len is parity: pkt_err = (accumulator != byte), then -> DONE.
  - rx_ready low stops new reads only. A byte already in flight is still presented with rx_valid, and the sink must absorb it.
  - len=0: only the parity byte is read; no rx_valid pulses.
- DONE:
  - pkt_done=1 for one cycle; pkt_err is held until the next pkt_done.
  - pkt_count += 1.
  - -> IDLE.
- soft_reset=1 in any state except IDLE:
  - -> IDLE next cycle; read_enb=0 that same cycle.
  - pkt_abort=1 for one cycle.
  - No pkt_done, pkt_count unchanged, rx_valid suppressed for any in-flight byte.
- soft_reset in IDLE: ignored.
- Back-to-back packets: after DONE, IDLE re-detects vld_out; the full DELAY is applied per packet.
- reset mid-packet: immediate return to reset state, no abort pulse.

Optional Feature:
- Macro: ROUTER_RD_TIMEOUT_EN.
- Defined:
  - In HDR_RD or BODY, a counter increments on each cycle with no read_enb and clears on read_enb.
  - Reaching TIMEOUT -> IDLE with pkt_abort=1, same as the soft_reset path.
- Undefined: no counter; the reader waits indefinitely for vld_out/rx_ready.

Test Plan:
- Good packet: header 8'h0D (len=3, addr=1), payload 11/22/33, parity 8'h0D; rx_ready=1.
  - -> rx_data 11,22,33 on three rx_valid pulses; pkt_done=1, pkt_err=0, pkt_len=3, pkt_addr=1, pkt_count=1.
  - read_enb rises READ_DELAY+1 cycles after vld_out.
- Bad parity: same packet with parity 8'h0E -> pkt_done=1 with pkt_err=1; pkt_count increments.
- Throttle: rx_ready=0 for 5 cycles after first payload read -> exactly one further byte delivered (the in-flight one), no read_enb during the stall, all 3 bytes delivered in order.
- Zero-length: header 8'h02, parity 8'h02 -> one body read, no rx_valid, pkt_done=1, pkt_err=0, pkt_addr=2.
- Abort: soft_reset pulse after 2nd payload byte -> pkt_abort=1, no pkt_done, read_enb=0 within 1 cycle, busy=0, pkt_count unchanged.
- Timeout (macro on, TIMEOUT=8): vld_out low for 8 cycles in BODY -> pkt_abort=1, state IDLE.

Source files
------------

// File: rtl/router_dest_reader.sv
// Destination-side packet reader for one router output port: header, payload, parity.
// Optional stall timeout, enabled by defining ROUTER_RD_TIMEOUT_EN.
module router_dest_reader #(
  parameter int READ_DELAY = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       vld_out,
  input  logic [7:0] data_out,
  input  logic       soft_reset,
  input  logic       rx_ready,
  output logic       read_enb,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic [1:0] pkt_addr,
  output logic [5:0] pkt_len,
  output logic       pkt_done,
  output logic       pkt_err,
  output logic       pkt_abort,
  output logic [7:0] pkt_count,
  output logic       busy
);
  // state   | meaning
  // IDLE    | waiting for vld_out
  // DELAY   | holding off READ_DELAY cycles before the header read
  // HDR_RD  | header read strobe, issued only while vld_out=1
  // HDR_CAP | header byte on data_out: latch length, address, parity seed
  // BODY    | reading payload + parity, streaming payload to the sink
  // DONE    | pkt_done pulse, then back to IDLE
  typedef enum logic [2:0] {IDLE, DELAY, HDR_RD, HDR_CAP, BODY, DONE} state_t;

  localparam logic [4:0] DLY_LAST = (READ_DELAY > 0) ? 5'(READ_DELAY - 1) : 5'd0;

  state_t     state;
  logic [4:0] dly_cnt;
  logic [6:0] rd_left;
  logic [5:0] pay_left;
  logic [7:0] parity_acc;
  logic       rd_pend;
  logic       tmo_hit;

  // Combinational so the strobe never outlives vld_out and drops in the soft_reset cycle.
  assign read_enb = ~soft_reset & vld_out &
                    ((state == HDR_RD) |
                     ((state == BODY) & rx_ready & (rd_left != 7'd0)));

`ifdef ROUTER_RD_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
  logic [15:0] tmo_left;
  logic        tmo_armed;

  assign tmo_armed = (state == HDR_RD) || (state == BODY);
  assign tmo_hit   = tmo_armed && !read_enb && (tmo_left == 16'd0);

  always_ff @(posedge clock) begin
    if (reset || read_enb || !tmo_armed)
      tmo_left <= TMO_LAST;
    else if (tmo_left != 16'd0)
      tmo_left <= tmo_left - 16'd1;
  end
`else
  // Stall timer not built: never fires for any legal TIMEOUT.
  assign tmo_hit = (TIMEOUT < 0);
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      dly_cnt    <= 5'd0;
      rd_left    <= 7'd0;
      pay_left   <= 6'd0;
      parity_acc <= 8'd0;
      rd_pend    <= 1'b0;
      rx_data    <= 8'd0;
      rx_valid   <= 1'b0;
      pkt_addr   <= 2'd0;
      pkt_len    <= 6'd0;
      pkt_done   <= 1'b0;
      pkt_err    <= 1'b0;
      pkt_abort  <= 1'b0;
      pkt_count  <= 8'd0;
      busy       <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      pkt_done  <= 1'b0;
      pkt_abort <= 1'b0;
      rd_pend   <= read_enb & (state == BODY);
      if ((soft_reset || tmo_hit) && (state != IDLE)) begin
        // Abandon the packet; any byte already in flight is dropped silently.
        state     <= IDLE;
        busy      <= 1'b0;
        pkt_abort <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (vld_out) begin
              dly_cnt <= 5'd0;
              busy    <= 1'b1;
              state   <= (READ_DELAY == 0) ? HDR_RD : DELAY;
            end
          end
          DELAY: begin
            if (!vld_out) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else if (dly_cnt == DLY_LAST) begin
              state <= HDR_RD;
            end else begin
              dly_cnt <= dly_cnt + 5'd1;
            end
          end
          HDR_RD: begin
            if (read_enb) state <= HDR_CAP;
          end
          HDR_CAP: begin
            pkt_len    <= data_out[7:2];
            pkt_addr   <= data_out[1:0];
            parity_acc <= data_out;
            rd_left    <= {1'b0, data_out[7:2]} + 7'd1;
            pay_left   <= data_out[7:2];
            state      <= BODY;
          end
          BODY: begin
            if (read_enb) rd_left <= rd_left - 7'd1;
            if (rd_pend) begin
              if (pay_left != 6'd0) begin
                rx_data    <= data_out;
                rx_valid   <= 1'b1;
                parity_acc <= parity_acc ^ data_out;
                pay_left   <= pay_left - 6'd1;
              end else begin
                pkt_err   <= (parity_acc != data_out);
                pkt_done  <= 1'b1;
                pkt_count <= pkt_count + 8'd1;
                state     <= DONE;
              end
            end
          end
          DONE: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_router_dest_reader.sv
// Scoreboard bench for router_dest_reader: a FIFO model feeds packets, a monitor
// checks every rx byte, done and abort against expectations queued by the stimulus.
`timescale 1ns/1ps
module tb_router_dest_reader;
  localparam int READ_DELAY = 4;
  localparam int TIMEOUT    = 8;
  localparam int EV_BYTE  = 0;
  localparam int EV_DONE  = 1;
  localparam int EV_ABORT = 2;

  typedef struct {
    int          kind;
    logic [31:0] val;
  } ev_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       vld_out;
  logic [7:0] data_out = 8'd0;
  logic       soft_reset = 1'b0;
  logic       rx_ready = 1'b1;
  logic       read_enb;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [1:0] pkt_addr;
  logic [5:0] pkt_len;
  logic       pkt_done;
  logic       pkt_err;
  logic       pkt_abort;
  logic [7:0] pkt_count;
  logic       busy;

  logic [7:0] mem [256];
  logic [7:0] wr_ptr = 8'd0;
  logic [7:0] rd_ptr = 8'd0;
  logic       vld_hold = 1'b0;

  ev_t exp_q[$];
  int  n_cmp = 0;
  int  n_err = 0;
  int  rxv_total = 0;
  int  exp_count = 0;

  router_dest_reader #(.READ_DELAY(READ_DELAY), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset), .vld_out(vld_out), .data_out(data_out),
    .soft_reset(soft_reset), .rx_ready(rx_ready), .read_enb(read_enb),
    .rx_data(rx_data), .rx_valid(rx_valid), .pkt_addr(pkt_addr), .pkt_len(pkt_len),
    .pkt_done(pkt_done), .pkt_err(pkt_err), .pkt_abort(pkt_abort),
    .pkt_count(pkt_count), .busy(busy)
  );

  always #5 clock = ~clock;

  // Router output FIFO model: one-cycle read latency.
  assign vld_out = (wr_ptr != rd_ptr) && !vld_hold;
  always @(posedge clock) begin
    if (read_enb) begin
      data_out <= mem[rd_ptr];
      rd_ptr   <= rd_ptr + 8'd1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic score(input int kind, input logic [31:0] val, input string name);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: got unexpected event %0h expected none", name, val);
    end else begin
      e = exp_q.pop_front();
      check({name, "_kind"}, kind, e.kind);
      check(name, val, e.val);
    end
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      if (rx_valid) begin
        rxv_total++;
        score(EV_BYTE, {24'd0, rx_data}, "rx_byte");
      end
      if (pkt_done) score(EV_DONE, {15'd0, pkt_count, pkt_err, pkt_len, pkt_addr}, "pkt_done");
      if (pkt_abort) score(EV_ABORT, 32'd0, "pkt_abort");
    end
  end

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic load(input logic [7:0] b);
    mem[wr_ptr] = b;
    wr_ptr = wr_ptr + 8'd1;
  endtask

  task automatic exp_byte(input logic [7:0] b);
    exp_q.push_back('{EV_BYTE, {24'd0, b}});
  endtask

  task automatic exp_done(input logic err, input logic [5:0] len, input logic [1:0] addr);
    logic [7:0] cnt;
    exp_count++;
    cnt = exp_count[7:0];
    exp_q.push_back('{EV_DONE, {15'd0, cnt, err, len, addr}});
  endtask

  task automatic exp_abort();
    exp_q.push_back('{EV_ABORT, 32'd0});
  endtask

  task automatic wait_idle(input string name);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (exp_q.size() == 0 && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    check({name, "_complete"}, {31'd0, ok}, 32'd1);
  endtask

  task automatic wait_rx(input int base, input int n);
    for (int i = 0; i < 200; i++) begin
      tick();
      if (rxv_total - base >= n) break;
    end
  endtask

  initial begin
    int         lat;
    int         base;
    int         nre;
    int         rd_seen;
    logic [7:0] rd_base;
    logic [7:0] rd_diff;

    repeat (3) tick();
    check("reset_outputs", {2'd0, read_enb, rx_valid, rx_data, pkt_addr, pkt_len,
                            pkt_done, pkt_err, pkt_abort, pkt_count, busy}, 32'd0);
    check("reset_count", {24'd0, pkt_count}, 32'd0);
    reset = 1'b0;
    tick();

    // Good packet; header read latency READ_DELAY+1 cycles after vld_out
    exp_byte(8'h11); exp_byte(8'h22); exp_byte(8'h33); exp_done(1'b0, 6'd3, 2'd1);
    load(8'h0D); load(8'h11); load(8'h22); load(8'h33); load(8'h0D);
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clock);
      #1;
      if (read_enb) begin
        lat = i;
        break;
      end
    end
    check("hdr_read_latency", lat, READ_DELAY + 1);
    wait_idle("good_pkt");
    check("good_count", {24'd0, pkt_count}, 32'd1);
    check("good_len_addr", {24'd0, pkt_len, pkt_addr}, {24'd0, 6'd3, 2'd1});
    check("good_err", {31'd0, pkt_err}, 32'd0);

    // Bad parity; error flag held after the done pulse
    exp_byte(8'h11); exp_byte(8'h22); exp_byte(8'h33); exp_done(1'b1, 6'd3, 2'd1);
    load(8'h0D); load(8'h11); load(8'h22); load(8'h33); load(8'h0E);
    wait_idle("bad_parity");
    repeat (3) tick();
    check("bad_err_held", {31'd0, pkt_err}, 32'd1);
    check("bad_count", {24'd0, pkt_count}, 32'd2);

    // Throttle: sink stalls right after the first payload read
    exp_byte(8'hAA); exp_byte(8'hBB); exp_byte(8'hCC); exp_done(1'b0, 6'd3, 2'd1);
    load(8'h0D); load(8'hAA); load(8'hBB); load(8'hCC); load(8'hD0);
    nre = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (read_enb) nre++;
      if (nre >= 2) break;
    end
    tick();
    rx_ready = 1'b0;
    base = rxv_total;
    rd_seen = 0;
    #1;
    if (read_enb) rd_seen++;
    repeat (4) begin
      tick();
      if (read_enb) rd_seen++;
    end
    tick();
    check("stall_reads", rd_seen, 0);
    check("stall_bytes", rxv_total - base, 1);
    rx_ready = 1'b1;
    wait_idle("throttle");

    // Zero-length packet: only the parity byte is read
    exp_done(1'b0, 6'd0, 2'd2);
    base = rxv_total;
    rd_base = rd_ptr;
    load(8'h02); load(8'h02);
    wait_idle("zero_len");
    rd_diff = rd_ptr - rd_base;
    check("zero_len_reads", {24'd0, rd_diff}, 32'd2);
    check("zero_len_bytes", rxv_total - base, 0);
    check("zero_len_addr", {30'd0, pkt_addr}, 32'd2);

    // Soft-reset abort after the second payload byte
    exp_byte(8'h11); exp_byte(8'h22); exp_abort();
    load(8'h0D); load(8'h11); load(8'h22); load(8'h33); load(8'h0D);
    base = rxv_total;
    wait_rx(base, 2);
    soft_reset = 1'b1;
    #1;
    check("abort_read_enb", {31'd0, read_enb}, 32'd0);
    tick();
    soft_reset = 1'b0;
    wr_ptr = rd_ptr;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_count", {24'd0, pkt_count}, exp_count);
    wait_idle("abort");

    // Long vld_out stall in BODY: timeout abort if built in, otherwise waits it out
    exp_byte(8'h11); exp_byte(8'h22);
`ifdef ROUTER_RD_TIMEOUT_EN
    exp_abort();
`else
    exp_byte(8'h33); exp_done(1'b0, 6'd3, 2'd1);
`endif
    load(8'h0D); load(8'h11); load(8'h22); load(8'h33); load(8'h0D);
    base = rxv_total;
    wait_rx(base, 1);
    vld_hold = 1'b1;
    repeat (20) tick();
`ifdef ROUTER_RD_TIMEOUT_EN
    check("timeout_idle", {31'd0, busy}, 32'd0);
    wr_ptr = rd_ptr;
`else
    check("stall_still_busy", {31'd0, busy}, 32'd1);
`endif
    vld_hold = 1'b0;
    wait_idle("long_stall");

    // Back-to-back packets
    exp_byte(8'h5A); exp_byte(8'hA5); exp_done(1'b0, 6'd2, 2'd1);
    exp_byte(8'h3C); exp_done(1'b0, 6'd1, 2'd3);
    load(8'h09); load(8'h5A); load(8'hA5); load(8'hF6);
    load(8'h07); load(8'h3C); load(8'h3B);
    wait_idle("back_to_back");
    check("b2b_len_addr", {24'd0, pkt_len, pkt_addr}, {24'd0, 6'd1, 2'd3});

    // Reset mid-packet: clean return to reset state, no abort
    exp_byte(8'h11);
    load(8'h0D); load(8'h11); load(8'h22); load(8'h33); load(8'h0D);
    base = rxv_total;
    wait_rx(base, 1);
    reset = 1'b1;
    tick();
    tick();
    wr_ptr = rd_ptr;
    check("midreset_count", {24'd0, pkt_count}, 32'd0);
    check("midreset_busy", {31'd0, busy}, 32'd0);
    check("midreset_len", {26'd0, pkt_len}, 32'd0);
    reset = 1'b0;
    exp_count = 0;
    repeat (3) tick();
    check("scoreboard_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
